rx_block_sync: RTL and testbench
================================

RX_BLOCK_SYNC -- requirements
Module: rx_block_sync

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 128, giving the block payload width in bits (one 128b/130b block per beat).
REQ-002 The module SHALL have parameter ERR_LIMIT, default 4, giving the number of consecutive invalid sync headers that drops lock.
REQ-003 The module SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 The module SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The module SHALL have port in_valid, input, 1 bit: a block is present this cycle.
REQ-006 The module SHALL have port in_sync_hdr, input, 2 bits: block sync header; 2'b10 = data block, 2'b01 = ordered set.
REQ-007 The module SHALL have port in_data, input, DATA_WIDTH bits: block payload; symbol k = in_data[8k+7:8k].
REQ-008 The module SHALL have port out_valid, output, 1 bit: a forwarded block is present.
REQ-009 The module SHALL have port out_data, output, DATA_WIDTH bits: the forwarded payload, unmodified and still scrambled, sent on to the descrambler.
REQ-010 The module SHALL have port out_is_os, output, 1 bit: the forwarded block is an ordered set.
REQ-011 The module SHALL have port descr_seed, output, 1 bit: one-cycle pulse that re-seeds the downstream descrambler LFSR.
REQ-012 The module SHALL have port locked, output, 1 bit: block lock is achieved.
REQ-013 The module SHALL have port sync_err, output, 1 bit: one-cycle pulse on each invalid sync header seen while LOCKED.

Function
REQ-014 The module SHALL implement a two-state FSM, UNLOCKED and LOCKED; only beats with in_valid=1 affect it.
REQ-015 An EIEOS SHALL be a beat with in_sync_hdr=2'b01 whose symbols alternate 8'h00 and 8'hFF in pairs (symbols 0,1 = 00; 2,3 = FF; and so on).
REQ-016 In UNLOCKED, all beats SHALL be discarded (out_valid=0); an EIEOS moves the FSM to LOCKED, pulses descr_seed, and is not forwarded.
REQ-017 In LOCKED, a valid-header beat SHALL be forwarded with exactly one cycle of latency: registered out_data, out_is_os = (hdr==2'b01), and out_valid=1.
REQ-018 In LOCKED, a SKP OS (hdr 2'b01, symbol 0 = 8'hAA) SHALL be dropped (out_valid=0) and SHALL NOT advance the descrambler.
REQ-019 In LOCKED, an EIEOS SHALL be forwarded with out_is_os=1 and SHALL pulse descr_seed in the same cycle as its out_valid.
REQ-020 In LOCKED, an invalid header (2'b00 or 2'b11) SHALL NOT be forwarded, SHALL pulse sync_err, and SHALL increment the error counter.
REQ-021 Any valid-header beat SHALL clear the error counter to 0.
REQ-022 When the error counter reaches ERR_LIMIT, the FSM SHALL enter UNLOCKED on that edge, locked SHALL fall to 0, and the counter SHALL clear.
REQ-023 The error counter SHALL saturate and never wrap; its width is $clog2(ERR_LIMIT+1).
REQ-024 A beat with in_valid=0 SHALL produce out_valid=0, descr_seed=0, sync_err=0, and SHALL leave the counter unchanged.
REQ-025 locked SHALL equal (state==LOCKED), registered.

Reset
REQ-026 On reset_n=0 the module SHALL asynchronously force: state UNLOCKED, counter 0, out_valid 0, out_data 0, out_is_os 0, descr_seed 0, sync_err 0, locked 0.
REQ-027 A reset asserted mid-stream SHALL discard any in-flight beat; after release, no output SHALL be produced until an EIEOS is received.

Structure
REQ-028 The sync header codes (HDR_DATA, HDR_OS), SKP_SYM 8'hAA, the EIEOS pattern function, and the FSM state enum SHALL live in the shared package pcie_phy_pkg.
REQ-029 EIEOS/SKP detection SHALL be a combinational sub-module rx_os_detect (inputs hdr and data; outputs is_eieos and is_skp); the FSM and registers are top-level.

Verification
REQ-030 Reset, then 3 data blocks with no EIEOS -> out_valid stays 0 and locked=0.
REQ-031 EIEOS, then data blocks D1 and D2 -> descr_seed pulses once and locked=1 on the next edge; D1 appears on out_data one cycle after its input, then D2; out_is_os=0 throughout.
REQ-032 While locked, a SKP OS (symbol 0 = AA) between two data blocks -> only the two data blocks are output; no gap-filling beat is emitted.
REQ-033 While locked, 3 headers of 2'b00, one valid block, then 4 headers of 2'b11 -> 7 sync_err pulses; locked stays 1 after the 3 errors and falls on the edge of the 4th consecutive error.
REQ-034 Assert reset_n=0 for 1 cycle in the middle of a locked stream -> all outputs go to 0 immediately, locked=0, and the stream resumes only after the next EIEOS.
REQ-035 While locked, an EIEOS -> forwarded with out_is_os=1, and descr_seed=1 in the same cycle as its out_valid.

Source files
------------

// File: rtl/pcie_phy_pkg.sv
// Shared PCIe PHY receive definitions: sync header codes, ordered-set symbols,
// the EIEOS symbol pattern and the block-sync FSM state encoding.
package pcie_phy_pkg;

    localparam logic [1:0] HDR_DATA = 2'b10;
    localparam logic [1:0] HDR_OS   = 2'b01;
    localparam logic [7:0] SKP_SYM  = 8'hAA;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } sync_state_e;

    // EIEOS symbols run 00,00,FF,FF,00,00,... across the block.
    function automatic logic [7:0] eieos_sym(input int unsigned k);
        return (((k / 2) % 2) != 0) ? 8'hFF : 8'h00;
    endfunction

endpackage

// File: rtl/rx_os_detect.sv
// Combinational EIEOS / SKP ordered-set classifier for one received block.
import pcie_phy_pkg::*;

module rx_os_detect #(
    parameter int DATA_WIDTH = 128
) (
    input  logic [1:0]            hdr,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  is_eieos,
    output logic                  is_skp
);
    localparam int NSYM = DATA_WIDTH / 8;

    logic [NSYM-1:0] sym_ok;
    logic            is_os;

    for (genvar k = 0; k < NSYM; k++) begin : g_sym
        assign sym_ok[k] = (data[8*k +: 8] == eieos_sym(k));
    end

    assign is_os    = (hdr == HDR_OS);
    assign is_eieos = is_os && (&sym_ok);
    assign is_skp   = is_os && (data[7:0] == SKP_SYM);

endmodule

// File: rtl/rx_block_sync.sv
// 128b/130b receive block lock: acquires lock on EIEOS, forwards blocks while
// locked, drops SKP and bad-header beats, and loses lock after ERR_LIMIT errors.
import pcie_phy_pkg::*;

module rx_block_sync #(
    parameter int DATA_WIDTH = 128,
    parameter int ERR_LIMIT  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic [1:0]            in_sync_hdr,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_is_os,
    output logic                  descr_seed,
    output logic                  locked,
    output logic                  sync_err
);
    localparam int CW = $clog2(ERR_LIMIT + 1);
    localparam logic [CW-1:0] LAST_ERR = CW'(ERR_LIMIT - 1);

    sync_state_e   state;
    logic [CW-1:0] err_cnt;
    logic          is_eieos, is_skp, hdr_ok;

    rx_os_detect #(.DATA_WIDTH(DATA_WIDTH)) u_os_detect (
        .hdr      (in_sync_hdr),
        .data     (in_data),
        .is_eieos (is_eieos),
        .is_skp   (is_skp)
    );

    assign hdr_ok = (in_sync_hdr == HDR_DATA) || (in_sync_hdr == HDR_OS);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_UNLOCKED;
            err_cnt    <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_is_os  <= 1'b0;
            descr_seed <= 1'b0;
            sync_err   <= 1'b0;
            locked     <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            out_is_os  <= 1'b0;
            descr_seed <= 1'b0;
            sync_err   <= 1'b0;
            if (in_valid) begin
                case (state)
                    ST_UNLOCKED: begin
                        if (is_eieos) begin
                            state      <= ST_LOCKED;
                            locked     <= 1'b1;
                            descr_seed <= 1'b1;
                            err_cnt    <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        if (hdr_ok) begin
                            err_cnt <= '0;
                            // SKP is absorbed here so the descrambler never sees it.
                            if (!is_skp) begin
                                out_valid  <= 1'b1;
                                out_data   <= in_data;
                                out_is_os  <= (in_sync_hdr == HDR_OS);
                                descr_seed <= is_eieos;
                            end
                        end else begin
                            sync_err <= 1'b1;
                            // Hitting the limit unlocks and clears, so the count never wraps.
                            if (err_cnt >= LAST_ERR) begin
                                state   <= ST_UNLOCKED;
                                locked  <= 1'b0;
                                err_cnt <= '0;
                            end else begin
                                err_cnt <= err_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state  <= ST_UNLOCKED;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_block_sync.sv
// Randomized and directed bench for rx_block_sync against a behavioural lock model.
module tb_rx_block_sync;
    localparam int DW   = 128;
    localparam int EL   = 4;
    localparam int NSYM = DW / 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [1:0]    in_sync_hdr = 2'b00;
    logic [DW-1:0] in_data = '0;
    logic          out_valid, out_is_os, descr_seed, locked, sync_err;
    logic [DW-1:0] out_data;

    always #5 clk = ~clk;

    rx_block_sync #(.DATA_WIDTH(DW), .ERR_LIMIT(EL)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_sync_hdr (in_sync_hdr),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_is_os   (out_is_os),
        .descr_seed  (descr_seed),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    bit            m_locked = 0;
    int            m_errs   = 0;
    logic          exp_valid, exp_os, exp_seed, exp_err;
    logic [DW-1:0] exp_data = '0;

    function automatic logic [DW-1:0] mk_eieos();
        logic [DW-1:0] v;
        for (int k = 0; k < NSYM; k++) v[8*k +: 8] = ((k / 2) % 2 == 1) ? 8'hFF : 8'h00;
        return v;
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[32*i +: 32] = $urandom;
        if (v[7:0] == 8'hAA) v[7:0] = 8'h55;
        return v;
    endfunction

    function automatic logic [DW-1:0] mk_skp();
        logic [DW-1:0] v;
        v = rnd_data();
        v[7:0] = 8'hAA;
        return v;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_errs = 0; exp_data = '0;
        exp_valid = 0; exp_os = 0; exp_seed = 0; exp_err = 0;
    endtask

    // Drive one beat and predict what the DUT shows after the next edge.
    task automatic drive(input logic v, input logic [1:0] h, input logic [DW-1:0] d);
        bit good, eie, skp;
        @(negedge clk);
        in_valid = v; in_sync_hdr = h; in_data = d;
        exp_valid = 0; exp_seed = 0; exp_err = 0; exp_os = 0;
        if (v) begin
            good = (h == 2'b10) || (h == 2'b01);
            eie  = (h == 2'b01) && (d == mk_eieos());
            skp  = (h == 2'b01) && (d[7:0] == 8'hAA);
            if (!m_locked) begin
                if (eie) begin m_locked = 1; exp_seed = 1; m_errs = 0; end
            end else if (good) begin
                m_errs = 0;
                if (!skp) begin
                    exp_valid = 1; exp_data = d; exp_os = (h == 2'b01); exp_seed = eie;
                end
            end else begin
                exp_err = 1;
                m_errs  = m_errs + 1;
                if (m_errs >= EL) begin m_locked = 0; m_errs = 0; end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        n_checks++;
        if (out_valid !== 0 || out_data !== '0 || out_is_os !== 0 || descr_seed !== 0 ||
            locked !== 0 || sync_err !== 0)
            $display("FAIL reset: got v=%b d=%h os=%b seed=%b lk=%b err=%b want all zero",
                     out_valid, out_data, out_is_os, descr_seed, locked, sync_err);
        else n_pass++;
        @(negedge clk);
        reset_n = 1;
    endtask

    task automatic test_no_lock();
        for (int i = 0; i < 3; i++) begin
            drive(1, 2'b10, rnd_data());
            n_checks++;
            if (out_valid !== 0 || locked !== 0 || descr_seed !== 0 || sync_err !== 0)
                $display("FAIL no_lock beat %0d: got v=%b lk=%b seed=%b err=%b want 0 0 0 0",
                         i, out_valid, locked, descr_seed, sync_err);
            else n_pass++;
        end
    endtask

    task automatic test_lock_data();
        int seeds = 0;
        logic [DW-1:0] d1, d2;
        d1 = rnd_data(); d2 = rnd_data();
        drive(1, 2'b01, mk_eieos());
        seeds += descr_seed;
        n_checks++;
        if (locked !== 1 || out_valid !== 0 || descr_seed !== 1)
            $display("FAIL lock_eieos: got lk=%b v=%b seed=%b want 1 0 1", locked, out_valid, descr_seed);
        else n_pass++;
        drive(1, 2'b10, d1);
        seeds += descr_seed;
        n_checks++;
        if (out_valid !== 1 || out_data !== d1 || out_is_os !== 0 || locked !== 1)
            $display("FAIL lock_d1: got v=%b os=%b lk=%b d=%h want 1 0 1 d=%h", out_valid, out_is_os, locked, out_data, d1);
        else n_pass++;
        drive(1, 2'b10, d2);
        seeds += descr_seed;
        n_checks++;
        if (out_valid !== 1 || out_data !== d2 || out_is_os !== 0)
            $display("FAIL lock_d2: got v=%b os=%b d=%h want 1 0 d=%h", out_valid, out_is_os, out_data, d2);
        else n_pass++;
        n_checks++;
        if (seeds !== 1) $display("FAIL lock_seed_count: got %0d want 1", seeds);
        else n_pass++;
    endtask

    task automatic test_skp();
        int outs = 0;
        logic [DW-1:0] d3, d4;
        d3 = rnd_data(); d4 = rnd_data();
        drive(1, 2'b10, d3);
        outs += out_valid;
        drive(1, 2'b01, mk_skp());
        outs += out_valid;
        n_checks++;
        if (out_valid !== 0 || descr_seed !== 0 || sync_err !== 0)
            $display("FAIL skp_drop: got v=%b seed=%b err=%b want 0 0 0", out_valid, descr_seed, sync_err);
        else n_pass++;
        drive(1, 2'b10, d4);
        outs += out_valid;
        n_checks++;
        if (out_valid !== 1 || out_data !== d4)
            $display("FAIL skp_next: got v=%b d=%h want 1 d=%h", out_valid, out_data, d4);
        else n_pass++;
        n_checks++;
        if (outs !== 2) $display("FAIL skp_count: got %0d want 2", outs);
        else n_pass++;
    endtask

    task automatic test_sync_err();
        int errs = 0;
        logic [1:0] hs [8] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11};
        for (int i = 0; i < 8; i++) begin
            drive(1, hs[i], rnd_data());
            errs += sync_err;
            n_checks++;
            if (sync_err !== exp_err || locked !== m_locked || out_valid !== exp_valid)
                $display("FAIL sync_err beat %0d: got err=%b lk=%b v=%b want %b %b %b",
                         i, sync_err, locked, out_valid, exp_err, m_locked, exp_valid);
            else n_pass++;
        end
        n_checks++;
        if (errs !== 7 || locked !== 0) $display("FAIL sync_err_total: got %0d lk=%b want 7 lk=0", errs, locked);
        else n_pass++;
    endtask

    task automatic test_eieos_locked();
        drive(1, 2'b01, mk_eieos());
        drive(0, 2'b10, rnd_data());
        drive(1, 2'b01, mk_eieos());
        n_checks++;
        if (out_valid !== 1 || out_is_os !== 1 || descr_seed !== 1 || out_data !== mk_eieos())
            $display("FAIL eieos_locked: got v=%b os=%b seed=%b want 1 1 1", out_valid, out_is_os, descr_seed);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        logic [DW-1:0] d;
        drive(1, 2'b10, rnd_data());
        reset_n = 0;
        #1;
        model_reset();
        n_checks++;
        if (out_valid !== 0 || out_data !== '0 || locked !== 0 || descr_seed !== 0 || out_is_os !== 0)
            $display("FAIL mid_reset: got v=%b lk=%b seed=%b os=%b d=%h want all zero",
                     out_valid, locked, descr_seed, out_is_os, out_data);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 2'b10, rnd_data());
            n_checks++;
            if (out_valid !== 0 || locked !== 0)
                $display("FAIL mid_reset_hold %0d: got v=%b lk=%b want 0 0", i, out_valid, locked);
            else n_pass++;
        end
        drive(1, 2'b01, mk_eieos());
        d = rnd_data();
        drive(1, 2'b10, d);
        n_checks++;
        if (out_valid !== 1 || out_data !== d || locked !== 1)
            $display("FAIL mid_reset_resume: got v=%b lk=%b d=%h want 1 1 d=%h", out_valid, locked, out_data, d);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [1:0]    h;
        logic [DW-1:0] d;
        logic          v;
        int            sel;
        for (int i = 0; i < 600; i++) begin
            sel = $urandom_range(0, 15);
            v = (sel != 0);
            d = rnd_data();
            h = 2'b10;
            if (sel inside {1, 2}) begin h = 2'b01; d = mk_eieos(); end
            else if (sel == 3) begin h = 2'b01; d = mk_skp(); end
            else if (sel == 4) h = 2'b01;
            else if (sel inside {5, 6, 7}) h = (($urandom & 1) != 0) ? 2'b11 : 2'b00;
            drive(v, h, d);
            n_checks++;
            if (out_valid !== exp_valid || descr_seed !== exp_seed || sync_err !== exp_err ||
                locked !== m_locked || (exp_valid && (out_data !== exp_data || out_is_os !== exp_os)))
                $display("FAIL random beat %0d: got v=%b seed=%b err=%b lk=%b os=%b d=%h want v=%b seed=%b err=%b lk=%b os=%b d=%h",
                         i, out_valid, descr_seed, sync_err, locked, out_is_os, out_data,
                         exp_valid, exp_seed, exp_err, m_locked, exp_os, exp_data);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_no_lock();
        test_lock_data();
        test_skp();
        test_sync_err();
        test_eieos_locked();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
